// File: rtl/tdm_transmit.sv
// TDM serial transmitter: serializes SLOTS samples per frame onto sd_out, framed by external SCK/WS.
// Optional TDM_TX_HOLD_ON_UNDERRUN_EN: on underrun, resend the last transmitted frame instead of zeros.
module tdm_transmit #(
   parameter int unsigned SLOTS        = 4,
   parameter int unsigned SAMPLE_WIDTH = 24,
   parameter int unsigned SLOT_WIDTH   = 32
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          sck_in,
   input  logic                          ws_in,
   input  logic [SLOTS*SAMPLE_WIDTH-1:0] audio_in,
   input  logic                          valid_in,
   output logic                          ready_out,
   output logic                          sd_out,
   output logic                          busy_out,
   output logic                          frame_done_out,
   output logic                          underrun_out
);

   localparam int unsigned FrameW   = SLOTS * SAMPLE_WIDTH;
   localparam int unsigned SlotCntW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int unsigned BitCntW  = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
   localparam logic [SlotCntW-1:0] LastSlot = SlotCntW'(SLOTS - 1);
   localparam logic [BitCntW-1:0]  LastBit  = BitCntW'(SLOT_WIDTH - 1);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e                r_state;
   logic [2:0]            r_sck_sync;
   logic [2:0]            r_ws_sync;
   logic                  r_start_pending;
   logic [FrameW-1:0]     r_hold;
   logic                  r_hold_empty;
   logic [FrameW-1:0]     r_frame;
   logic [SlotCntW-1:0]   r_slot;
   logic [BitCntW-1:0]    r_bit;
   logic                  r_sd;
   logic                  r_busy;
   logic                  r_frame_done;
   logic                  r_underrun;

   logic                  w_sck_rise;
   logic                  w_sck_fall;
   logic                  w_ws_high;
   logic                  w_start;
   logic                  w_last;
   logic [SlotCntW-1:0]   w_next_slot;
   logic [BitCntW-1:0]    w_next_bit;
   logic [FrameW-1:0]     w_load_frame;

   // Serial bit for (slot, bit-in-slot); bits past SAMPLE_WIDTH are zero padding.
   function automatic logic f_bit(input logic [FrameW-1:0]   frame,
                                  input logic [SlotCntW-1:0] slot,
                                  input logic [BitCntW-1:0]  b);
      logic v;
      v = 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
         for (int k = 0; k < SAMPLE_WIDTH; k++) begin
            if (slot == SlotCntW'(s) && b == BitCntW'(SAMPLE_WIDTH - 1 - k)) begin
               v = frame[s*SAMPLE_WIDTH + k];
            end
         end
      end
      return v;
   endfunction

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_sck_sync <= '0;
         r_ws_sync  <= '0;
      end else begin
         r_sck_sync <= {r_sck_sync[1:0], sck_in};
         r_ws_sync  <= {r_ws_sync[1:0], ws_in};
      end
   end

   assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
   assign w_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];
   // WS must be high in both late stages so a WS edge racing the SCK rise is not half-seen.
   assign w_ws_high  = r_ws_sync[1] & r_ws_sync[2];
   assign w_start    = w_sck_fall & r_start_pending;
   assign w_last     = (r_slot == LastSlot) && (r_bit == LastBit);

   always_comb begin
      w_next_bit  = r_bit + 1'b1;
      w_next_slot = r_slot;
      if (r_bit == LastBit) begin
         w_next_bit  = '0;
         w_next_slot = r_slot + 1'b1;
      end
   end

`ifdef TDM_TX_HOLD_ON_UNDERRUN_EN
   // r_frame still holds the last transmitted frame, so it doubles as the shadow copy.
   assign w_load_frame = r_hold_empty ? r_frame : r_hold;
`else
   assign w_load_frame = r_hold_empty ? '0 : r_hold;
`endif

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state         <= StIdle;
         r_start_pending <= 1'b0;
         r_hold          <= '0;
         r_hold_empty    <= 1'b1;
         r_frame         <= '0;
         r_slot          <= '0;
         r_bit           <= '0;
         r_sd            <= 1'b0;
         r_busy          <= 1'b0;
         r_frame_done    <= 1'b0;
         r_underrun      <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         r_underrun   <= 1'b0;

         if (w_start) begin
            r_start_pending <= 1'b0;
         end else if (w_sck_rise && w_ws_high) begin
            r_start_pending <= 1'b1;
         end

         // Capture needs an empty buffer and a load needs a full one, so they never collide.
         if (valid_in && r_hold_empty) begin
            r_hold       <= audio_in;
            r_hold_empty <= 1'b0;
         end else if (w_start && !r_hold_empty) begin
            r_hold_empty <= 1'b1;
         end

         if (w_start) begin
            r_frame      <= w_load_frame;
            r_slot       <= '0;
            r_bit        <= '0;
            r_sd         <= w_load_frame[SAMPLE_WIDTH-1];
            r_busy       <= 1'b1;
            r_underrun   <= r_hold_empty;
            r_frame_done <= (r_state == StShift) && w_last;
            r_state      <= StShift;
         end else begin
            unique case (r_state)
               StIdle: begin
                  r_sd   <= 1'b0;
                  r_busy <= 1'b0;
               end
               StShift: begin
                  if (w_sck_fall) begin
                     if (w_last) begin
                        r_state      <= StIdle;
                        r_sd         <= 1'b0;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                     end else begin
                        r_slot <= w_next_slot;
                        r_bit  <= w_next_bit;
                        r_sd   <= f_bit(r_frame, w_next_slot, w_next_bit);
                     end
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign ready_out      = r_hold_empty;
   assign sd_out         = r_sd;
   assign busy_out       = r_busy;
   assign frame_done_out = r_frame_done;
   assign underrun_out   = r_underrun;

endmodule

// File: tb/tb_tdm_transmit.sv
// Directed bench for tdm_transmit: SCK of 20 clk periods, frames checked as 128-bit captured streams.
module tb_tdm_transmit;

   localparam int FW = 96;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          sck    = 1'b1;
   logic          ws     = 1'b0;
   logic          valid  = 1'b0;
   logic [FW-1:0] audio  = '0;
   logic          ready;
   logic          sd;
   logic          busy;
   logic          done;
   logic          ur;

   tdm_transmit #(
      .SLOTS        (4),
      .SAMPLE_WIDTH (24),
      .SLOT_WIDTH   (32)
   ) dut (
      .clk_in         (clk),
      .rst_in         (rst_n),
      .sck_in         (sck),
      .ws_in          (ws),
      .audio_in       (audio),
      .valid_in       (valid),
      .ready_out      (ready),
      .sd_out         (sd),
      .busy_out       (busy),
      .frame_done_out (done),
      .underrun_out   (ur)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_err  = 0;
   int n_done = 0;
   int n_ur   = 0;
   int n_rdy  = 0;

   always @(negedge clk) begin
      if (done)  n_done = n_done + 1;
      if (ur)    n_ur   = n_ur + 1;
      if (ready) n_rdy  = n_rdy + 1;
   end

   localparam logic [FW-1:0] FA = {24'hA5A5A5, 24'h000000, 24'h7FFFFF, 24'h800001};
   localparam logic [FW-1:0] FB = {24'h000003, 24'hC00000, 24'h123456, 24'hFEDCBA};
   localparam logic [FW-1:0] FC = {24'h0F0F0F, 24'hF0F0F0, 24'h555555, 24'hAAAAAA};
   localparam logic [FW-1:0] FD = {24'h000001, 24'h800000, 24'h3C3C3C, 24'h900009};
   localparam logic [FW-1:0] FE = {24'h000000, 24'hFFFFFF, 24'h000000, 24'h000000};
   localparam logic [FW-1:0] FF = {24'h654321, 24'h000080, 24'h010000, 24'hE00007};
   localparam logic [FW-1:0] FG = {24'h7E7E7E, 24'h000100, 24'hFFFF00, 24'hC0FFEE};
   localparam logic [127:0] A_STREAM = 128'h800001_00_7FFFFF_00_000000_00_A5A5A5_00;

   // Wire order: slot 0 first, each slot = 24 sample bits MSB-first then 8 zeros.
   function automatic logic [127:0] exp_stream(input logic [FW-1:0] fr);
      logic [127:0] s;
      s = '0;
      for (int sl = 0; sl < 4; sl++) s[127-32*sl -: 32] = {fr[24*sl +: 24], 8'h00};
      return s;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One SCK period: fall (ws updated), sample sd at the end of the low phase, then rise.
   task automatic sck_period(input logic ws_v, input int vld_at, output logic sd_s,
                             output logic busy_s);
      @(negedge clk);
      sck = 1'b0;
      ws  = ws_v;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (vld_at > 0) valid = (k == vld_at);
      end
      sd_s   = sd;
      busy_s = busy;
      sck    = 1'b1;
      repeat (9) @(negedge clk);
   endtask

   task automatic run_frame(input logic ws_last, input int vld0, output logic [127:0] got,
                            output int busy_n);
      logic sd_s, b_s;
      busy_n = 0;
      got    = '0;
      for (int i = 0; i < 128; i++) begin
         sck_period(ws_last && (i == 127), (i == 0) ? vld0 : 0, sd_s, b_s);
         got[127-i] = sd_s;
         busy_n += int'(b_s);
      end
   endtask

   task automatic pulse_valid(input logic [FW-1:0] fr);
      @(negedge clk);
      audio = fr;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
   endtask

   logic [127:0] got;
   logic [127:0] exp_c;
   logic [40:0]  part;
   int           bn;
   int           d0, u0, r0;
   logic         sd_s, b_s;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_sd", sd, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_underrun", ur, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Basic frame
      pulse_valid(FA);
      check("t1_ready_low", ready, 0);
      d0 = n_done; u0 = n_ur;
      sck_period(1'b1, 0, sd_s, b_s);
      run_frame(1'b0, 0, got, bn);
      check("t1_stream", got, A_STREAM);
      check("t1_busy_periods", bn, 128);
      check("t1_ready_high", ready, 1);
      sck_period(1'b0, 0, sd_s, b_s);
      check("t1_tail_busy", b_s, 0);
      check("t1_tail_sd", sd_s, 0);
      check("t1_done", n_done - d0, 1);
      check("t1_no_underrun", n_ur - u0, 0);

      // Underrun
      d0 = n_done; u0 = n_ur;
      sck_period(1'b1, 0, sd_s, b_s);
      run_frame(1'b0, 0, got, bn);
`ifdef TDM_TX_HOLD_ON_UNDERRUN_EN
      check("t2_stream", got, A_STREAM);
`else
      check("t2_stream", got, 128'h0);
`endif
      check("t2_busy_periods", bn, 128);
      sck_period(1'b0, 0, sd_s, b_s);
      check("t2_underrun", n_ur - u0, 1);
      check("t2_done", n_done - d0, 1);

      // valid held high, back-to-back frames
      @(negedge clk);
      audio = FB;
      valid = 1'b1;
      @(negedge clk);
      audio = FC;
      check("t3_ready_low", ready, 0);
      r0 = n_rdy; d0 = n_done; u0 = n_ur;
      sck_period(1'b1, 0, sd_s, b_s);
      run_frame(1'b1, 0, got, bn);
      check("t3_b_stream", got, exp_stream(FB));
      check("t3_b_ready_cycles", n_rdy - r0, 1);
      r0 = n_rdy;
      run_frame(1'b0, 0, got, bn);
      check("t3_c_stream", got, exp_stream(FC));
      check("t3_c_ready_cycles", n_rdy - r0, 1);
      valid = 1'b0;
      sck_period(1'b0, 0, sd_s, b_s);
      check("t3_done", n_done - d0, 2);
      check("t3_no_underrun", n_ur - u0, 0);
      check("t3_buffer_full", ready, 0);

      // Resync after 40 bits
      d0 = n_done; u0 = n_ur;
      exp_c = exp_stream(FC);
      sck_period(1'b1, 0, sd_s, b_s);
      audio = FD;
      for (int i = 0; i <= 40; i++) begin
         sck_period(i == 40, (i == 1) ? 5 : 0, sd_s, b_s);
         part[40-i] = sd_s;
      end
      check("t4_partial", part, exp_c[127:87]);
      run_frame(1'b0, 0, got, bn);
      check("t4_no_done_on_abort", n_done - d0, 0);
      check("t4_new_stream", got, exp_stream(FD));
      sck_period(1'b0, 0, sd_s, b_s);
      check("t4_done", n_done - d0, 1);
      check("t4_no_underrun", n_ur - u0, 0);

      // Asynchronous reset mid-slot 2
      pulse_valid(FE);
      sck_period(1'b1, 0, sd_s, b_s);
      audio = FF;
      for (int i = 0; i < 70; i++) sck_period(1'b0, (i == 5) ? 3 : 0, sd_s, b_s);
      check("t5_sd_before", sd_s, 1);
      check("t5_busy_before", b_s, 1);
      check("t5_ready_before", ready, 0);
      d0 = n_done;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t5_rst_sd", sd, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_ready", ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      check("t5_no_done", n_done - d0, 0);
      pulse_valid(FF);
      d0 = n_done; u0 = n_ur;
      sck_period(1'b1, 0, sd_s, b_s);
      run_frame(1'b0, 0, got, bn);
      check("t5_clean_stream", got, exp_stream(FF));
      sck_period(1'b0, 0, sd_s, b_s);
      check("t5_done", n_done - d0, 1);
      check("t5_no_underrun", n_ur - u0, 0);

      // Capture coincident with frame start on an empty buffer
      d0 = n_done; u0 = n_ur;
      sck_period(1'b1, 0, sd_s, b_s);
      audio = FG;
      run_frame(1'b0, 2, got, bn);
`ifdef TDM_TX_HOLD_ON_UNDERRUN_EN
      check("t6_stream", got, exp_stream(FF));
`else
      check("t6_stream", got, 128'h0);
`endif
      check("t6_underrun", n_ur - u0, 1);
      check("t6_buffer_full", ready, 0);
      sck_period(1'b0, 0, sd_s, b_s);
      check("t6_done", n_done - d0, 1);
      u0 = n_ur;
      sck_period(1'b1, 0, sd_s, b_s);
      run_frame(1'b0, 0, got, bn);
      check("t6_next_stream", got, exp_stream(FG));
      sck_period(1'b0, 0, sd_s, b_s);
      check("t6_next_no_underrun", n_ur - u0, 0);
      check("t6_ready_after", ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/tdm_transmit.md
Name: tdm_transmit

Overview:
- TDM serial transmitter. It is the transmit-side counterpart of the TDM microphone receiver.
- Serializes one frame of SLOTS audio samples onto a single data line, framed by an externally supplied bit clock (sck_in) and frame sync (ws_in).
- Used to drive a TDM DAC/codec from the beamformer output, and as a loopback source for exercising the receive path.
- Frames are accepted through a valid/ready handshake into a one-frame holding buffer (double-buffered against the shift register).

Parameters:
- SLOTS, 4, number of TDM slots per frame.
- SAMPLE_WIDTH, 24, significant bits per slot sample, sent MSB-first.
- SLOT_WIDTH, 32, SCK cycles per slot; bits after SAMPLE_WIDTH are zero padding; must be ≥ SAMPLE_WIDTH.

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  asynchronous, active-low reset.
- sck_in  input  1  TDM bit clock; oversampled by clk_in, at least 8 clk_in cycles per SCK period.
- ws_in  input  1  frame sync; high for one SCK period.
- audio_in  input  SLOTS*SAMPLE_WIDTH  packed frame; slot 0 in bits [SAMPLE_WIDTH-1:0].
- valid_in  input  1  audio_in holds a frame.
- ready_out  output  1  holding buffer empty; the frame is accepted when valid_in && ready_out.
- sd_out  output  1  serial data.
- busy_out  output  1  a frame is being shifted.
- frame_done_out  output  1  one-cycle pulse after the last bit of slot SLOTS-1 is driven.
- underrun_out  output  1  one-cycle pulse when a frame starts with the holding buffer empty.

Behaviour:
- Reset (rst_in low, asynchronous):
  - sd_out=0, busy_out=0, frame_done_out=0, underrun_out=0, ready_out=1.
  - Holding buffer empty; shift register zeroed; bit/slot counters 0; sync flops 0.
  - Reset asserted mid-frame aborts the frame immediately; no frame_done_out pulse.
- Synchronization and edge detection:
  - sck_in and ws_in each pass through a 2-flop synchronizer, followed by a third flop for edge detection.
  - Rise = s3 low, s2 high. Fall = s3 high, s2 low.
- Frame sync:
  - On a detected rise with synchronized ws high, arm frame start (start_pending=1).
  - On the next detected fall, begin the frame.
  - The receiver therefore captures slot 0 MSB on the SCK rise one full SCK period after the ws rise.
- States: IDLE, SHIFT.
  - IDLE:
    - sd_out=0.
    - On a fall with start_pending set: load the frame, drive bit 0, go to SHIFT, set busy_out=1.
  - SHIFT:
    - Each detected fall drives the next bit.
    - Bit index b within the slot: b < SAMPLE_WIDTH drives sample bit SAMPLE_WIDTH-1-b; otherwise drives 0.
    - When b reaches SLOT_WIDTH-1, advance the slot.
    - The fall after the last bit of slot SLOTS-1: sd_out=0, busy_out=0, frame_done_out pulses, go to IDLE.
- Frame load at frame start:
  - If the holding buffer is full, copy it into the shift register and mark it empty (ready_out=1 on the next cycle).
  - If the holding buffer is empty, load all-zero data and pulse underrun_out.
- Handshake:
  - ready_out = holding buffer empty.
  - A frame is captured on the clk_in edge where valid_in && ready_out.
  - While full, valid_in is ignored.
  - Capture and frame start on the same cycle with the buffer empty: the frame starts as an underrun, and the captured frame is kept for the next frame.
- ws while in SHIFT (resync): on the next fall, abort the current frame without a frame_done_out pulse, then perform a fresh frame start with the normal load rules.
- Latency: sd_out changes on the 3rd clk_in rising edge after the first edge that samples sck_in low.
- All outputs are registered.

Optional Feature:
- Macro: TDM_TX_HOLD_ON_UNDERRUN_EN.
- Defined: on underrun, the last transmitted frame is retained in a shadow register and resent; underrun_out still pulses.
- Undefined: on underrun, zeros are sent; no shadow register exists.

Test Plan:
- Reset, then a SCK of 20 clk_in cycles/period with ws every 128 SCK. Load slot0..3 = 24'h800001, 24'h7FFFFF, 24'h000000, 24'hA5A5A5 → a bit-exact 128-bit stream (each slot: 24 data bits MSB-first plus 8 zeros); frame_done_out pulses once; a connected tdm_receive outputs the same four values.
- No valid_in before ws → all 128 bits 0, underrun_out pulses once, busy_out high for exactly 128 SCK periods. With TDM_TX_HOLD_ON_UNDERRUN_EN, the previous frame is repeated instead.
- valid_in held high continuously → ready_out drops after capture and rises 1 cycle after the frame start; exactly one frame is consumed per ws; no underrun.
- ws asserted after 40 bits of a frame → the current frame is aborted with no frame_done_out; slot 0 MSB of the new frame is driven on the fall following that ws rise.
- rst_in pulsed low mid-slot 2 → sd_out=0, busy_out=0 and ready_out=1 immediately (asynchronously); the next ws starts a clean frame.
- ws rise coincident with valid_in while the buffer is empty → underrun_out pulses, zeros are sent, and the captured frame goes out on the following frame.
